crc_stream_core: RTL
====================

// Module: crc_stream_core
// PURPOSE
//  Parametrised, streaming CRC engine for the CRC peripheral family. Any polynomial/width 8..32,
//  runtime poly/init/xorout/refin/refout, valid/ready word input with partial final word.
//  Processes BITS_PER_CYCLE bits per clock. Register wrappers (APB4 etc.) instantiate it.
// PARAMETERS
//  CRC_WIDTH       32  CRC register width; legal 8..32
//  DATA_WIDTH      32  input word width; multiple of 8, 8..64
//  BITS_PER_CYCLE  8   bits folded per clock; legal 1,2,4,8
// PORTS
//  clk_i         in   1               clock; all logic on rising edge
//  rst_n_i       in   1               synchronous active-low reset
//  cfg_poly_i    in   CRC_WIDTH       polynomial, normal form, implicit x^CRC_WIDTH
//  cfg_init_i    in   CRC_WIDTH       initial CRC value
//  cfg_xorout_i  in   CRC_WIDTH       final XOR value
//  cfg_refin_i   in   1               reflect each input byte
//  cfg_refout_i  in   1               reflect CRC before final XOR
//  clr_i         in   1               start new message: latch cfg_*, load init
//  dat_valid_i   in   1               input word valid
//  dat_ready_o   out  1               engine can accept a word
//  dat_i         in   DATA_WIDTH      input word; byte lane 0 = dat_i[7:0] processed first
//  dat_nbytes_i  in   $clog2(DATA_WIDTH/8)+1  valid lanes 0..n-1; values >DATA_WIDTH/8 clamped
//  dat_last_i    in   1               word ends message
//  crc_o         out  CRC_WIDTH       final CRC; valid while crc_valid_o=1
//  crc_valid_o   out  1               final CRC available
//  busy_o        out  1               state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, crc reg=0, shadow cfg=0, crc_o=0, crc_valid_o=0, busy_o=0; dat_ready_o=1.
//  cfg_* sampled only on clr_i cycle into shadow regs; changes elsewhere have no effect.
//  clr_i: crc reg<=cfg_init_i, crc_valid_o<=0, state<=IDLE; aborts BUSY/FINAL; clr_i has priority
//   over handshake: dat_ready_o = (state==IDLE) && !clr_i.
//  FSM: IDLE -(valid&&ready, n>0)-> BUSY; IDLE -(valid&&ready, n==0, last)-> FINAL;
//   IDLE -(valid&&ready, n==0, !last)-> IDLE (word dropped, no effect);
//   BUSY -(steps done, last)-> FINAL; BUSY -(steps done, !last)-> IDLE; FINAL -> IDLE.
//  Accept: word, n, last captured in one cycle; BUSY lasts n*8/BITS_PER_CYCLE cycles exactly.
//  Each step folds BITS_PER_CYCLE bits MSB-first of current byte (byte bit-reversed first if refin)
//   using shadow poly; lanes >= n ignored.
//  FINAL (1 cycle): crc_o <= (refout ? bitrev(crc) : crc) ^ xorout; crc_valid_o <= 1 next edge.
//  crc_valid_o/crc_o hold until clr_i or next accepted word (acceptance clears crc_valid_o).
//  Without clr_i, next word continues from running crc reg (append to message).
//  Throughput: 1 word per n*8/BITS_PER_CYCLE + 1 cycles; ready low while BUSY/FINAL.
//  Latency: last word accepted at edge t -> crc_valid_o high after edge t+steps+1.
//  crc reg masked to CRC_WIDTH; upper poly/init/xorout bits beyond CRC_WIDTH don't exist.
//  Reset mid-operation: returns to reset values next edge regardless of state.
// TESTING
//  CRC-32 (04C11DB7, init FFFFFFFF, xor FFFFFFFF, refin/out=1), "123456789" as 3 words (4,4,1 bytes, last on 3rd) -> CBF43926
//  CRC_WIDTH=16, poly 1021, init FFFF, xor 0, no reflect, "123456789" -> 29B1; repeat with BITS_PER_CYCLE=1,2,4 -> identical
//  CRC_WIDTH=8, poly 07, init 00, xor 00, "123456789" -> F4; CRC_WIDTH=16 poly 8005 refin/out=1 init 0 -> BB3D
//  Word accepted with nbytes=0,last=1 after clr_i (init FFFF, xor 0) -> crc_o=FFFF, valid 2 edges after accept
//  clr_i asserted with dat_valid_i same cycle -> ready=0, word not consumed; clr_i mid-BUSY -> IDLE, valid=0, crc reg=init
//  Change cfg_poly_i while BUSY -> result unchanged; rst_n_i low mid-BUSY -> all outputs at reset values next edge

Source files
------------

// File: rtl/crc_stream_core.sv
// crc_stream_core
// Streaming CRC engine: accepts one word at a time through a valid/ready
// handshake and folds BITS_PER_CYCLE message bits into the CRC register per
// clock. Byte lane 0 of each word goes first, and each byte is taken MSB-first.
// When the input is reflected, the bits of each byte are reversed as the word
// is captured. The polynomial, XOR-out and reflection settings are copied into
// shadow registers on clr_i, so the configuration inputs may change freely
// while a message is being processed. A message may span any number of words;
// the word flagged last produces the final CRC.

module crc_stream_core #(
  parameter int CRC_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [CRC_WIDTH-1:0]            cfg_poly_i,
  input  logic [CRC_WIDTH-1:0]            cfg_init_i,
  input  logic [CRC_WIDTH-1:0]            cfg_xorout_i,
  input  logic                            cfg_refin_i,
  input  logic                            cfg_refout_i,
  input  logic                            clr_i,
  input  logic                            dat_valid_i,
  output logic                            dat_ready_o,
  input  logic [DATA_WIDTH-1:0]           dat_i,
  input  logic [$clog2(DATA_WIDTH/8):0]   dat_nbytes_i,
  input  logic                            dat_last_i,
  output logic [CRC_WIDTH-1:0]            crc_o,
  output logic                            crc_valid_o,
  output logic                            busy_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int NB_W  = $clog2(LANES) + 1;
  // A bit position within the word is {lane index, bit-in-byte}.
  localparam int CNT_W = NB_W + 3;

  localparam logic [NB_W-1:0]  LANES_N = NB_W'(LANES);
  localparam logic [CNT_W-1:0] STEP_N  = CNT_W'(BITS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FINAL
  } state_e;

  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  poly_q, poly_d;
  logic [CRC_WIDTH-1:0]  xorout_q, xorout_d;
  logic                  refin_q, refin_d;
  logic                  refout_q, refout_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      total_bits_q, total_bits_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  last_q, last_d;
  logic [CRC_WIDTH-1:0]  crc_out_q, crc_out_d;
  logic                  crc_valid_q, crc_valid_d;

  logic                  accept;
  logic [NB_W-1:0]       nbytes_clamped;
  logic [CNT_W-1:0]      bit_base;
  logic [7:0]            cur_byte;
  logic [7:0]            aligned_byte;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [CRC_WIDTH-1:0]  crc_folded;

  // Reverses the bit order inside every byte lane of a word.
  function automatic logic [DATA_WIDTH-1:0] reflect_lanes(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[l*8+b] = w[l*8+7-b];
      end
    end
    return r;
  endfunction

  // Reverses the bit order of a whole CRC value.
  function automatic logic [CRC_WIDTH-1:0] reflect_crc(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < CRC_WIDTH; j++) begin
      r[j] = c[CRC_WIDTH-1-j];
    end
    return r;
  endfunction

  // Shifts BITS_PER_CYCLE bits into the CRC, taking them from the top of 'aligned' downwards.
  function automatic logic [CRC_WIDTH-1:0] fold_bits(input logic [CRC_WIDTH-1:0] c,
                                                     input logic [CRC_WIDTH-1:0] poly,
                                                     input logic [7:0]           aligned);
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = c;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      fb = r[CRC_WIDTH-1] ^ aligned[7-k];
      r  = {r[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{fb}} & poly);
    end
    return r;
  endfunction

  assign dat_ready_o = (state_q == ST_IDLE) && !clr_i;
  assign accept      = dat_valid_i && dat_ready_o;
  assign busy_o      = (state_q != ST_IDLE);
  assign crc_o       = crc_out_q;
  assign crc_valid_o = crc_valid_q;

  // Select the current byte, align the next unprocessed bit to bit 7, and fold one step.
  always_comb begin
    nbytes_clamped = (dat_nbytes_i > LANES_N) ? LANES_N : dat_nbytes_i;
    bit_base       = {bit_cnt_q[CNT_W-1:3], 3'b000};
    cur_byte       = 8'(word_q >> bit_base);
    aligned_byte   = cur_byte << bit_cnt_q[2:0];
    bit_cnt_next   = bit_cnt_q + STEP_N;
    crc_folded     = fold_bits(crc_q, poly_q, aligned_byte);
  end

  // Next-state logic: clr_i overrides everything; otherwise IDLE -> BUSY -> (FINAL) -> IDLE.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    poly_d       = poly_q;
    xorout_d     = xorout_q;
    refin_d      = refin_q;
    refout_d     = refout_q;
    word_d       = word_q;
    total_bits_d = total_bits_q;
    bit_cnt_d    = bit_cnt_q;
    last_d       = last_q;
    crc_out_d    = crc_out_q;
    crc_valid_d  = crc_valid_q;

    if (clr_i) begin
      state_d     = ST_IDLE;
      crc_d       = cfg_init_i;
      poly_d      = cfg_poly_i;
      xorout_d    = cfg_xorout_i;
      refin_d     = cfg_refin_i;
      refout_d    = cfg_refout_i;
      crc_valid_d = 1'b0;
      bit_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (nbytes_clamped != '0 || dat_last_i)) begin
            crc_valid_d  = 1'b0;
            word_d       = refin_q ? reflect_lanes(dat_i) : dat_i;
            total_bits_d = {nbytes_clamped, 3'b000};
            bit_cnt_d    = '0;
            last_d       = dat_last_i;
            state_d      = (nbytes_clamped != '0) ? ST_BUSY : ST_FINAL;
          end
        end
        ST_BUSY: begin
          crc_d     = crc_folded;
          bit_cnt_d = bit_cnt_next;
          if (bit_cnt_next == total_bits_q) begin
            state_d = last_q ? ST_FINAL : ST_IDLE;
          end
        end
        ST_FINAL: begin
          crc_out_d   = (refout_q ? reflect_crc(crc_q) : crc_q) ^ xorout_q;
          crc_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, shadow configuration and result registers; all clear on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      crc_q        <= '0;
      poly_q       <= '0;
      xorout_q     <= '0;
      refin_q      <= 1'b0;
      refout_q     <= 1'b0;
      word_q       <= '0;
      total_bits_q <= '0;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      crc_out_q    <= '0;
      crc_valid_q  <= 1'b0;
    end else begin
      crc_q        <= crc_d;
      poly_q       <= poly_d;
      xorout_q     <= xorout_d;
      refin_q      <= refin_d;
      refout_q     <= refout_d;
      word_q       <= word_d;
      total_bits_q <= total_bits_d;
      bit_cnt_q    <= bit_cnt_d;
      last_q       <= last_d;
      crc_out_q    <= crc_out_d;
      crc_valid_q  <= crc_valid_d;
    end
  end

endmodule
